// File: rtl/cube_seq_pkg.sv
// rtl/cube_seq_pkg.sv - shared types and default widths for the cube sequencer
package cube_seq_pkg;

    localparam int CUBE_XW = 2;
    localparam int CUBE_RW = 3 * CUBE_XW;

    typedef enum logic [0:0] {
        S_IDLE,
        S_WAIT
    } cube_seq_state_t;

endpackage

// File: rtl/cube_seq_fifo.sv
// rtl/cube_seq_fifo.sv - small sample FIFO feeding the cube sequencer
module cube_seq_fifo
    import cube_seq_pkg::*;
#(
    parameter int XW    = CUBE_XW,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [XW-1:0] data_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [XW-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [XW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          full_q;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && (count_q != '0);
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; simultaneous push and pop leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; full is registered so in_ready has no combinational path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= (count_d == FULL_CNT);
        end
    end

    // Storage needs no reset; head is only meaningful while not empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cube_poly_sequencer.sv
// rtl/cube_poly_sequencer.sv - feeds samples to seq_cube_poly and collects cubes
module cube_poly_sequencer
    import cube_seq_pkg::*;
#(
    parameter int XW      = CUBE_XW,
    parameter int RW      = CUBE_RW,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    output logic          cube_start,
    output logic [XW-1:0] cube_x,
    input  logic          cube_finish,
    input  logic [RW-1:0] cube_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_y,
    output logic          busy,
    output logic          err_timeout,
    input  logic          err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);

    cube_seq_state_t state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [RW-1:0]   out_y_q, out_y_d;
    logic            err_q, err_d;
    logic            timeout_hit;
    logic            fifo_full;
    logic            fifo_empty;

    cube_seq_fifo #(
        .XW    (XW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid),
        .data_i  (in_x),
        .pop_i   (cube_start),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (cube_x)
    );

    assign in_ready    = !fifo_full;
    assign out_valid   = out_valid_q;
    assign out_y       = out_y_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;

    // Issue/wait sequencing, output hand-off and sticky timeout flag
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        err_d       = err_q;
        cube_start  = 1'b0;
        timeout_hit = 1'b0;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Hold off while a result is still undelivered
                if (!fifo_empty && !out_valid_q) begin
                    cube_start = 1'b1;
                    state_d    = S_WAIT;
                    cnt_d      = CW'(1);
                end
            end
            S_WAIT: begin
                // First WAIT cycle ignores finish; it may be left over from the previous op
                if ((cnt_q != CW'(1)) && cube_finish) begin
                    out_y_d     = cube_result;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (err_clr)     err_d = 1'b0;
        if (timeout_hit) err_d = 1'b1;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_cube_poly_sequencer.sv
// tb/tb_cube_poly_sequencer.sv - scoreboard bench for cube_poly_sequencer
module tb_cube_poly_sequencer;
    import cube_seq_pkg::*;

    localparam int XW      = 2;
    localparam int RW      = 6;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] in_x = '0;
    logic          cube_start;
    logic [XW-1:0] cube_x;
    logic          cube_finish;
    logic [RW-1:0] cube_result;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [RW-1:0] out_y;
    logic          busy;
    logic          err_timeout;
    logic          err_clr = 1'b0;

    logic          stub_mode = 1'b0;
    logic          drop_mode = 1'b0;
    logic          saw_full = 1'b0;
    logic [1:0]    m_cnt;
    logic [RW-1:0] m_res;
    logic [RW-1:0] sb_q [$];
    logic [RW-1:0] exp_y;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    cube_poly_sequencer #(
        .XW(XW), .RW(RW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .cube_start  (cube_start),
        .cube_x      (cube_x),
        .cube_finish (cube_finish),
        .cube_result (cube_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_y       (out_y),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_clr     (err_clr)
    );

    function automatic logic [RW-1:0] cube_of(input logic [XW-1:0] x);
        logic [RW-1:0] w;
        w = RW'(x);
        return w * w * w;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stand-in for seq_cube_poly: finish three cycles after start, or never in stub mode
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 2'd0;
            m_res <= '0;
        end else if (cube_start) begin
            m_cnt <= 2'd3;
            m_res <= cube_of(cube_x);
        end else if (m_cnt != 2'd0) begin
            m_cnt <= m_cnt - 2'd1;
        end
    end
    assign cube_finish = !stub_mode && (m_cnt == 2'd1);
    assign cube_result = m_res;

    // Scoreboard producer: expected cube for every accepted sample
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready && !drop_mode) sb_q.push_back(cube_of(in_x));
    end

    // Scoreboard consumer and protocol monitors
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_y = sb_q.pop_front();
                    check("sb_out_y", 32'(out_y), 32'(exp_y));
                end
            end
            if (cube_start) check("start_legal", 32'(out_valid || (m_cnt != 2'd0)), 32'd0);
            if (!in_ready) saw_full = 1'b1;
        end
    end

    task automatic push_x(input logic [XW-1:0] x);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_x     = x;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("push_bound", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || out_valid || sb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 300), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int starts;
        int outv;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_y", 32'(out_y), 32'd0);
        check("rst_cube_start", 32'(cube_start), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single sample, latency and pulse width
        push_x(2'd3);
        @(negedge clk);
        check("t1_start", 32'(cube_start), 32'd1);
        check("t1_cube_x", 32'(cube_x), 32'd3);
        n = 0;
        starts = 0;
        do begin
            @(negedge clk);
            n++;
            if (cube_start) starts++;
        end while (!out_valid && n < 20);
        check("t1_latency", 32'(n), 32'd4);
        check("t1_restart", 32'(starts), 32'd0);
        check("t1_out_y", 32'(out_y), 32'd27);
        wait_idle("t1_idle");

        // 2: back-to-back burst fills the FIFO
        saw_full = 1'b0;
        push_x(2'd1);
        push_x(2'd2);
        push_x(2'd3);
        push_x(2'd0);
        push_x(2'd1);
        wait_idle("t2_idle");
        check("t2_saw_full", 32'(saw_full), 32'd1);

        // 3: back-pressure holds the result and blocks new starts
        out_ready = 1'b0;
        push_x(2'd2);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t3_valid_bound", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1;
        push_x(2'd1);
        push_x(2'd3);
        push_x(2'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 32'(out_valid), 32'd1);
            check("t3_hold_y", 32'(out_y), 32'd8);
            check("t3_no_start", 32'(cube_start), 32'd0);
            check("t3_in_ready", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle("t3_idle");

        // 4: unit never finishes -> timeout, sample dropped, next sample issued
        stub_mode = 1'b1;
        drop_mode = 1'b1;
        push_x(2'd1);
        push_x(2'd2);
        n = 0;
        outv = 0;
        do begin
            @(negedge clk);
            n++;
            if (out_valid) outv++;
        end while (!err_timeout && n < 30);
        check("t4_timeout_at", 32'(n), 32'd8);
        check("t4_next_start", 32'(cube_start), 32'd1);
        repeat (12) begin
            @(negedge clk);
            if (out_valid) outv++;
        end
        check("t4_no_out_valid", 32'(outv), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        @(posedge clk);
        #1;
        stub_mode = 1'b0;
        drop_mode = 1'b0;

        // 5: err_clr clears the sticky flag
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("t5_err_clr", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #1;

        // 6: reset during WAIT with two samples queued
        push_x(2'd1);
        push_x(2'd2);
        push_x(2'd3);
        check("t6_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_cube_start", 32'(cube_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        outv = 0;
        starts = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) outv++;
            if (cube_start) starts++;
        end
        check("t6_no_stale_out", 32'(outv), 32'd0);
        check("t6_no_stale_start", 32'(starts), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
